ppu_requant_pack: RTL and testbench

PPU_REQUANT_PACK -- requirements
Module: ppu_requant_pack

---
 rtl/ppu_requant_pack.sv | 132 +++++++++++++
 tb/tb_ppu_requant_pack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_requant_pack.sv
// Post-processing unit: requantizes signed psums to uint8 (zero-point 128),
// with optional ReLU and saturation, and packs four bytes per output word.
module ppu_requant_pack #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          cfg_len,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [DATA_BITS-1:0] opsum,
  input  logic                 opsum_valid,
  output logic                 opsum_ready,
  output logic [DATA_BITS-1:0] ofmap_data,
  output logic                 ofmap_valid,
  input  logic                 ofmap_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StAccept, StEmit, StFin} state_e;

  state_e               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [4:0]           shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic [1:0]           byte_q, byte_d;
  logic [DATA_BITS-1:0] pack_q, pack_d;

  logic signed [32:0]   ext, bias, r;
  logic [7:0]           qbyte;

  // Requantize the incoming psum: round-half-up shift, ReLU, saturate, bias by 128.
  always_comb begin
    ext  = 33'($signed(opsum));
    // Bias is zero for shift 0, so the same expression covers the pass-through case.
    bias = (shift_q == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift_q - 5'd1));
    r    = (ext + bias) >>> shift_q;
    if (relu_q && r[32]) begin
      r = 33'sd0;
    end
    if (r > 33'sd127) begin
      r = 33'sd127;
    end else if (r < -33'sd128) begin
      r = -33'sd128;
    end
    qbyte = r[7:0] ^ 8'h80;
  end

  // Next-state and output decode for the job sequencer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    byte_d      = byte_q;
    pack_d      = pack_q;
    opsum_ready = 1'b0;
    ofmap_valid = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = cfg_len;
          shift_d = cfg_shift;
          relu_d  = cfg_relu;
          cnt_d   = 16'd0;
          byte_d  = 2'd0;
          pack_d  = '0;
          state_d = (cfg_len != 16'd0) ? StAccept : StFin;
        end
      end
      StAccept: begin
        opsum_ready = 1'b1;
        if (opsum_valid) begin
          pack_d[byte_q*8 +: 8] = qbyte;
          byte_d = byte_q + 2'd1;
          cnt_d  = cnt_q + 16'd1;
          if (byte_q == 2'd3 || cnt_d == len_q) begin
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        ofmap_valid = 1'b1;
        if (ofmap_ready) begin
          if (cnt_q == len_q) begin
            state_d = StFin;
          end else begin
            pack_d  = '0;
            byte_d  = 2'd0;
            state_d = StAccept;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ofmap_data = pack_q;

  // State, configuration, counters and pack register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      shift_q <= 5'd0;
      relu_q  <= 1'b0;
      byte_q  <= 2'd0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      byte_q  <= byte_d;
      pack_q  <= pack_d;
    end
  end

endmodule

// File: tb/tb_ppu_requant_pack.sv
// Self-checking bench for ppu_requant_pack: directed vectors plus random jobs
// checked against a plain-arithmetic reference model.
module tb_ppu_requant_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [31:0] opsum;
  logic        opsum_valid;
  logic        opsum_ready;
  logic [31:0] ofmap_data;
  logic        ofmap_valid;
  logic        ofmap_ready;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  int          psum_q[$];
  logic [31:0] exp_q[$];

  ppu_requant_pack #(.DATA_BITS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .opsum       (opsum),
    .opsum_valid (opsum_valid),
    .opsum_ready (opsum_ready),
    .ofmap_data  (ofmap_data),
    .ofmap_valid (ofmap_valid),
    .ofmap_ready (ofmap_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference requantization straight from the arithmetic definition.
  function automatic logic [7:0] ref_byte(input int p, input int sh, input bit relu);
    longint v;
    v = longint'(p);
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v) ^ 8'h80;
  endfunction

  task automatic build_expected(input int len, input int sh, input bit relu);
    logic [31:0] word;
    exp_q.delete();
    word = 32'd0;
    for (int i = 0; i < len; i++) begin
      word = word | (32'(ref_byte(psum_q[i], sh, relu)) << (8 * (i % 4)));
      if ((i % 4) == 3 || i == len - 1) begin
        exp_q.push_back(word);
        word = 32'd0;
      end
    end
  endtask

  function automatic int rand_psum();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom_range(0, 2097152)) - 1048576;
      default: return int'($urandom);
    endcase
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 hold ready low for 3 EMIT cycles per word.
  task automatic run_job(input int len, input int sh, input bit relu, input int ready_mode,
                         input int valid_pct, input bit use_given, input bit noise_start);
    int idx, cyc, vcnt, last_hs;
    bit done_seen, pending;
    if (!use_given) build_expected(len, sh, relu);
    idx = 0; vcnt = 0; last_hs = 0; done_seen = 0; pending = 0;
    @(negedge clk);
    cfg_len = 16'(len); cfg_shift = 5'(sh); cfg_relu = relu; start = 1'b1;
    opsum_valid = 1'b0; ofmap_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cfg_len = 16'($urandom); cfg_shift = 5'($urandom); cfg_relu = 1'($urandom);
    for (cyc = 1; cyc < 2000; cyc++) begin
      if (pending) check_eq("word_latency", 32'(ofmap_valid), 32'd1);
      pending = 0;
      if (ofmap_valid) begin
        check_eq("ready_in_emit", 32'(opsum_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", 32'(ofmap_valid), 32'd0);
          ofmap_ready = 1'b1;
        end else begin
          check_eq("ofmap_data", ofmap_data, exp_q[0]);
          vcnt++;
          case (ready_mode)
            0:       ofmap_ready = 1'b1;
            1:       ofmap_ready = 1'($urandom_range(0, 1));
            default: ofmap_ready = (vcnt > 3);
          endcase
          if (ofmap_ready) begin
            if (ready_mode == 2) check_eq("bp_cycles", 32'(vcnt), 32'd4);
            void'(exp_q.pop_front());
            last_hs = cyc;
            vcnt = 0;
          end
        end
      end else begin
        ofmap_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        done_seen = 1;
        if (len == 0) check_eq("empty_done_lat", 32'(cyc), 32'd1);
        else          check_eq("done_lat", 32'(cyc), 32'(last_hs + 1));
        start = 1'b0;
        opsum_valid = 1'b0;
        break;
      end
      if (opsum_ready) begin
        opsum_valid = (idx < len) && (int'($urandom_range(0, 99)) < valid_pct);
        opsum = (idx < len) ? psum_q[idx] : $urandom;
      end else begin
        // Valid noise while not accepting must be ignored.
        opsum_valid = 1'($urandom_range(0, 1));
        opsum = $urandom;
      end
      if (opsum_valid && opsum_ready) begin
        idx++;
        if ((idx % 4) == 0 || idx == len) pending = 1;
      end
      start = noise_start && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    check_eq("job_done_seen", 32'(done_seen), 32'd1);
    check_eq("words_left", 32'(exp_q.size()), 32'd0);
    check_eq("psums_used", 32'(idx), 32'(len));
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_opsum_ready"}, 32'(opsum_ready), 32'd0);
    check_eq({tag, "_ofmap_valid"}, 32'(ofmap_valid), 32'd0);
    check_eq({tag, "_ofmap_data"}, ofmap_data, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = 16'd0; cfg_shift = 5'd0; cfg_relu = 1'b0;
    opsum = 32'd0; opsum_valid = 1'b0; ofmap_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Saturation vector.
    psum_q = '{1, -1, 200, -300};
    exp_q.delete(); exp_q.push_back(32'h00FF7F81);
    run_job(4, 0, 1'b0, 0, 100, 1'b1, 1'b0);

    // Rounding vector.
    psum_q = '{6, -6, 2, -3};
    exp_q.delete(); exp_q.push_back(32'h7F817F82);
    run_job(4, 2, 1'b0, 0, 100, 1'b1, 1'b0);

    // ReLU with partial final word.
    psum_q = '{-5, 7, 0, 127, -1};
    exp_q.delete(); exp_q.push_back(32'hFF808780); exp_q.push_back(32'h00000080);
    run_job(5, 0, 1'b1, 0, 100, 1'b1, 1'b0);

    // Backpressure on every word, with start pulses while busy.
    psum_q.delete();
    for (int i = 0; i < 10; i++) psum_q.push_back(rand_psum());
    run_job(10, 3, 1'b0, 2, 100, 1'b0, 1'b1);

    // Empty job.
    psum_q.delete();
    run_job(0, 0, 1'b0, 0, 100, 1'b0, 1'b0);

    // Reset after two transfers of a word.
    @(negedge clk);
    cfg_len = 16'd4; cfg_shift = 5'd0; cfg_relu = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opsum_valid = 1'b1; opsum = 32'd50;
    @(negedge clk);
    opsum = 32'd60;
    @(negedge clk);
    opsum_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midword_reset");
    @(negedge clk);
    rst = 1'b0; ofmap_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_reset_valid", 32'(ofmap_valid), 32'd0);
      check_eq("post_reset_busy", 32'(busy), 32'd0);
    end
    psum_q = '{-128, 3, 90, -40};
    run_job(4, 0, 1'b0, 0, 100, 1'b0, 1'b0);

    // Random jobs.
    for (int j = 0; j < 30; j++) begin
      int len;
      len = $urandom_range(0, 13);
      psum_q.delete();
      for (int i = 0; i < len; i++) psum_q.push_back(rand_psum());
      run_job(len, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1, 70, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
